seq_addsub: RTL

- Parametrised, multi-cycle add/subtract unit; successor to the 32-bit combinational subtractor.
- Processes CHUNK bits per clock using one narrow ripple adder, trading latency for area.
- Adds a runtime add/sub mode, a start/ready/done handshake, and status flags (carry, signed overflow, zero, negative).
- Sits beside the ALU datapath for wide operands, where a full-width combinational adder misses timing.

---
 rtl/seq_addsub_pkg.sv | 14 +
 rtl/seq_addsub_chunk.sv | 21 ++
 rtl/seq_addsub.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: FSM state encoding
// and operation mode constants.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_chunk.sv
// Combinational W-bit ripple adder slice; also reports the carry into its MSB
// so the parent can derive signed overflow on the final slice.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         cmsb
);

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    {cout, z} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    // The MSB sum bit is x^y^carry_in, so the incoming carry falls out by XOR.
    cmsb = z[W-1] ^ x[W-1] ^ y[W-1];
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: one CHUNK-wide adder walks the operands LSB-first,
// then commits result and flags in a single edge.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  state_t state, state_next;
  logic   accept, commit;

  logic [WIDTH-1:0] op_x, op_y, acc, acc_next;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] slice_x, slice_y, slice_z;
  logic             slice_cout, slice_cmsb;

  adder_chunk #(.W(CHUNK)) u_adder (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry),
    .z    (slice_z),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    slice_x  = op_x[idx*CHUNK +: CHUNK];
    slice_y  = op_y[idx*CHUNK +: CHUNK];
    acc_next = acc;
    acc_next[idx*CHUNK +: CHUNK] = slice_z;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        accept     = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next != RUN);
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // NOTE: operand/accumulator registers are not reset; every operation loads them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_x  <= x;
      op_y  <= y ^ {WIDTH{sub == OP_SUB}};
      carry <= (sub == OP_ADD) ? cin : 1'b1;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= slice_cout;
      idx   <= idx + 1'b1;
    end
  end

  // Results update only on commit, so partial sums never become visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b1;
      neg  <= 1'b0;
    end else if (commit) begin
      z    <= acc_next;
      cout <= slice_cout;
      ovf  <= slice_cout ^ slice_cmsb;
      zero <= (acc_next == '0);
      neg  <= acc_next[WIDTH-1];
    end
  end

endmodule
